// File: rtl/frame_capture_ctrl_if.sv
// Frame capture controller bus: sensor timing, capture control and
// frame-buffer write port grouped together.
interface frame_capture_ctrl_if #(
  parameter int unsigned ADDR_W = 21
);
  logic              iLineValid;
  logic              iFrameValid;
  logic              iStart;
  logic              iStop;
  logic              iContinuous;
  logic              oWrEn;
  logic [ADDR_W-1:0] oWrAddr;
  logic              oBusy;
  logic              oDone;
  logic [11:0]       oWidth;
  logic [11:0]       oHeight;
  logic              oOverflow;
  logic              oTimeout;

  modport slave (
    input  iLineValid, iFrameValid, iStart, iStop, iContinuous,
    output oWrEn, oWrAddr, oBusy, oDone, oWidth, oHeight, oOverflow, oTimeout
  );

  modport master (
    output iLineValid, iFrameValid, iStart, iStop, iContinuous,
    input  oWrEn, oWrAddr, oBusy, oDone, oWidth, oHeight, oOverflow, oTimeout
  );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: arms on iStart, aligns to a frame boundary,
// issues one buffer write per accepted pixel and reports measured frame size.
// Optional: define FRAME_CAPTURE_TIMEOUT_EN to abort SYNC/WAIT_FRAME after
// TIMEOUT cycles and raise oTimeout.
module frame_capture_ctrl #(
  parameter int unsigned MAX_W   = 1280,
  parameter int unsigned MAX_H   = 960,
  parameter int unsigned ADDR_W  = 21,
  parameter int unsigned TIMEOUT = 50000000
) (
  input  logic                iClk,
  input  logic                iRst_n,
  frame_capture_ctrl_if.slave bus
);

  localparam int unsigned     AddrCntW    = ADDR_W + 1;
  localparam int unsigned     FrameWords  = MAX_W * MAX_H;
  localparam logic [ADDR_W:0] FrameWordsA = AddrCntW'(FrameWords);
  localparam logic [ADDR_W:0] AddrOne     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [11:0]     MaxW        = 12'(MAX_W);
  localparam logic [11:0]     MaxH        = 12'(MAX_H);

  typedef enum logic [1:0] {StIdle, StSync, StWaitFrame, StCapture} state_e;

  state_e            stateQ, stateD;
  logic              rLineValidL, rFrameValidL;
  logic              contQ, contD;
  logic [ADDR_W:0]   addrQ, addrD;
  logic [11:0]       pixCntQ, pixCntD;
  logic [11:0]       lineCntQ, lineCntD;
  logic              ovfFrameQ, ovfFrameD;
  logic              ovfQ, ovfD;
  logic              wrEnQ, wrEnD;
  logic [ADDR_W-1:0] wrAddrQ, wrAddrD;
  logic              doneQ, doneD;
  logic [11:0]       widthQ, widthD;
  logic [11:0]       heightQ, heightD;

`ifdef FRAME_CAPTURE_TIMEOUT_EN
  localparam int unsigned TmoW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  logic [TmoW-1:0] tmoCntQ, tmoCntD;
  logic            tmoFlagQ, tmoFlagD;
`endif

  logic        lvRise, lvFall, fvRise, fvFall, pixel;
  logic [11:0] pixBase, pixNext;
  logic        pixOver, lineOver, addrFull;

  assign lvRise   = bus.iLineValid & ~rLineValidL;
  assign lvFall   = ~bus.iLineValid & rLineValidL;
  assign fvRise   = bus.iFrameValid & ~rFrameValidL;
  assign fvFall   = ~bus.iFrameValid & rFrameValidL;
  assign pixel    = bus.iLineValid & bus.iFrameValid;
  // A rising LV starts a new line, so the pixel on that cycle is number 1.
  assign pixBase  = lvRise ? 12'd0 : pixCntQ;
  assign pixNext  = pixBase + 12'd1;
  assign pixOver  = pixNext > MaxW;
  assign lineOver = lineCntQ >= MaxH;
  assign addrFull = (addrQ == FrameWordsA) | addrQ[ADDR_W];

  // Next-state and datapath updates; iStop overrides everything else.
  always_comb begin
    stateD    = stateQ;
    contD     = contQ;
    addrD     = addrQ;
    pixCntD   = pixCntQ;
    lineCntD  = lineCntQ;
    ovfFrameD = ovfFrameQ;
    ovfD      = ovfQ;
    wrEnD     = 1'b0;
    wrAddrD   = wrAddrQ;
    doneD     = 1'b0;
    widthD    = widthQ;
    heightD   = heightQ;
`ifdef FRAME_CAPTURE_TIMEOUT_EN
    tmoCntD   = tmoCntQ;
    tmoFlagD  = tmoFlagQ;
`endif
    if (bus.iStop) begin
      stateD = StIdle;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (bus.iStart) begin
            stateD    = StSync;
            contD     = bus.iContinuous;
            ovfD      = 1'b0;
            addrD     = '0;
            pixCntD   = '0;
            lineCntD  = '0;
            ovfFrameD = 1'b0;
`ifdef FRAME_CAPTURE_TIMEOUT_EN
            tmoCntD   = '0;
            tmoFlagD  = 1'b0;
`endif
          end
        end
        StSync: begin
          // Never start mid-frame: wait for FV low first.
          if (!bus.iFrameValid) stateD = StWaitFrame;
        end
        StWaitFrame: begin
          if (fvRise) begin
            stateD    = StCapture;
            pixCntD   = '0;
            lineCntD  = '0;
            ovfFrameD = 1'b0;
`ifdef FRAME_CAPTURE_TIMEOUT_EN
            tmoCntD   = '0;
`endif
          end
        end
        StCapture: begin
          if (fvFall) begin
            widthD  = pixCntQ;
            // LV may drop on the same cycle as FV; count that line too.
            heightD = lineCntQ + {11'd0, lvFall};
            doneD   = 1'b1;
            if (contQ) begin
              addrD  = '0;
              stateD = StWaitFrame;
            end else begin
              stateD = StIdle;
            end
          end else begin
            if (lvFall) lineCntD = lineCntQ + 12'd1;
            if (pixel) begin
              pixCntD = pixNext;
              if (ovfFrameQ || pixOver || lineOver || addrFull) begin
                ovfFrameD = 1'b1;
                ovfD      = 1'b1;
              end else begin
                wrEnD   = 1'b1;
                wrAddrD = addrQ[ADDR_W-1:0];
                addrD   = addrQ + AddrOne;
              end
            end else if (lvRise) begin
              pixCntD = '0;
            end
          end
        end
        default: stateD = StIdle;
      endcase
`ifdef FRAME_CAPTURE_TIMEOUT_EN
      // Counts across SYNC and WAIT_FRAME; a frame start on the last cycle wins.
      if ((stateQ == StSync || stateQ == StWaitFrame) && stateD != StCapture) begin
        if (tmoCntQ == TmoLast) begin
          stateD   = StIdle;
          tmoFlagD = 1'b1;
        end else begin
          tmoCntD = tmoCntQ + TmoW'(1);
        end
      end
`endif
    end
  end

  // State, edge-detect and datapath registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateQ       <= StIdle;
      rLineValidL  <= 1'b0;
      rFrameValidL <= 1'b0;
      contQ        <= 1'b0;
      addrQ        <= '0;
      pixCntQ      <= '0;
      lineCntQ     <= '0;
      ovfFrameQ    <= 1'b0;
      ovfQ         <= 1'b0;
      wrEnQ        <= 1'b0;
      wrAddrQ      <= '0;
      doneQ        <= 1'b0;
      widthQ       <= '0;
      heightQ      <= '0;
`ifdef FRAME_CAPTURE_TIMEOUT_EN
      tmoCntQ      <= '0;
      tmoFlagQ     <= 1'b0;
`endif
    end else begin
      stateQ       <= stateD;
      rLineValidL  <= bus.iLineValid;
      rFrameValidL <= bus.iFrameValid;
      contQ        <= contD;
      addrQ        <= addrD;
      pixCntQ      <= pixCntD;
      lineCntQ     <= lineCntD;
      ovfFrameQ    <= ovfFrameD;
      ovfQ         <= ovfD;
      wrEnQ        <= wrEnD;
      wrAddrQ      <= wrAddrD;
      doneQ        <= doneD;
      widthQ       <= widthD;
      heightQ      <= heightD;
`ifdef FRAME_CAPTURE_TIMEOUT_EN
      tmoCntQ      <= tmoCntD;
      tmoFlagQ     <= tmoFlagD;
`endif
    end
  end

  assign bus.oWrEn     = wrEnQ;
  assign bus.oWrAddr   = wrAddrQ;
  assign bus.oBusy     = (stateQ != StIdle);
  assign bus.oDone     = doneQ;
  assign bus.oWidth    = widthQ;
  assign bus.oHeight   = heightQ;
  assign bus.oOverflow = ovfQ;
`ifdef FRAME_CAPTURE_TIMEOUT_EN
  assign bus.oTimeout  = tmoFlagQ;
`else
  assign bus.oTimeout  = 1'b0;
`endif

endmodule
